multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control FSM for the MiniSys CPU. It sequences the instruction fetch unit, register file, ALU and data memory over 2–5 cycles per instruction. It generates the fetch unit's `nPC_sel`/`j_sel` together with a PC write enable, and waits on a shared memory `mem_ready` handshake. Unknown instructions and memory timeouts halt the core with a sticky fault.

## Interface
Parameters:
- `MAX_WAIT`, default 15: maximum wait cycles for `mem_ready` before a timeout fault (range 1–255).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `opcode`  in  6  instruction[31:26], from the IR.
- `funct`  in  6  instruction[5:0], from the IR.
- `mem_ready`  in  1  memory access complete this cycle.
- `ir_we`  out  1  latch the fetched word into the IR.
- `pc_we`  out  1  fetch unit updates the PC this cycle.
- `nPC_sel`  out  2  next-PC select: 00 = +4, 10 = BEQ, 11 = BNE.
- `j_sel`  out  1  jump target select.
- `mem_re`  out  1  memory read (instruction or lw).
- `mem_we`  out  1  memory write (sw).
- `reg_we`  out  1  register file write.
- `reg_dst`  out  1  write-register select: 1 = rd, 0 = rt.
- `mem_to_reg`  out  1  write-back source: 1 = memory, 0 = ALU.
- `alu_src`  out  1  ALU B source: 1 = immediate, 0 = rt.
- `ext_op`  out  1  immediate extension: 1 = sign, 0 = zero.
- `alu_op`  out  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI.
- `state`  out  3  current FSM state (debug).
- `fault`  out  1  sticky halt flag.
- `retire_count`  out  32  count of retired instructions.

## Operation
- State encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Registered signals: `state`, `wait_cnt` (8 bit), `fault`, `retire_count`. All other outputs are combinational from `state`, `opcode`, `funct` and `mem_ready`.
- Any strobe not listed for a state is 0 in that state.

Supported opcodes:
- R-type 000000, with funct: addu 0x21 → ADD, subu 0x23 → SUB, and 0x24 → AND, or 0x25 → OR, slt 0x2A → SLT.
- ori 001101 → OR, zero-extended immediate.
- addiu 001001 → ADD, sign-extended.
- lui 001111 → LUI.
- lw 100011 and sw 101011 → ADD, sign-extended.
- beq 000100 and bne 000101 → SUB, rt source.
- j 000010.

State behaviour:
- FETCH: `mem_re` = 1.
  - If `mem_ready`: `ir_we` = 1, go to DECODE.
  - Otherwise `wait_cnt` increments. When it reaches `MAX_WAIT`, go to HALT and set `fault`.
- DECODE:
  - j: `pc_we` = 1, `j_sel` = 1, go to FETCH.
  - Valid opcode with valid funct: go to EXEC.
  - Anything else: go to HALT and set `fault`.
- EXEC: `alu_src`, `ext_op` and `alu_op` are driven for the instruction.
  - beq: `pc_we` = 1, `nPC_sel` = 10, go to FETCH.
  - bne: `pc_we` = 1, `nPC_sel` = 11, go to FETCH.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM: `mem_re` = 1 for lw, `mem_we` = 1 for sw. EXEC's ALU controls are held.
  - lw with `mem_ready`: go to WB.
  - sw with `mem_ready`: `pc_we` = 1, `nPC_sel` = 00, go to FETCH.
  - Timeout rule is the same as FETCH.
- WB: `reg_we` = 1, `pc_we` = 1, `nPC_sel` = 00, go to FETCH.
  - `reg_dst` = 1 for R-type, otherwise 0.
  - `mem_to_reg` = 1 for lw, otherwise 0.
  - ALU controls are held.
- HALT: all strobes are 0, `fault` = 1. The state is left only by `rst`.

Counters:
- `wait_cnt` clears on every state change and whenever `mem_ready` = 1.
- `retire_count` increments on every cycle with `pc_we` = 1. It wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (asynchronous): `state` = FETCH, `wait_cnt` = 0, `fault` = 0, `retire_count` = 0.
  - While in FETCH after reset: `mem_re` = 1, and `ir_we` follows `mem_ready`.
  - All other strobes are 0.
- Cycles per instruction with zero wait states: j 2, beq/bne 3, R-type/immediate 4, sw 4, lw 5. Each wait cycle adds 1.
- `pc_we` is asserted for exactly one cycle per retired instruction. The fetch unit samples `nPC_sel`/`j_sel` only on that edge.
- The branch decision uses the ALU zero flag from the same EXEC cycle.
- Timeout: with `mem_ready` low, HALT is entered at the edge ending the `MAX_WAIT`-th wait cycle.
  - `mem_ready` arriving in that same cycle takes priority: the access completes, with no fault.
- `rst` asserted mid-instruction aborts it immediately. No strobe is asserted after the reset edge except FETCH's `mem_re`.
- `mem_ready` is ignored in DECODE, EXEC, WB and HALT.

## Test plan
- addu (opcode 0, funct 0x21), `mem_ready` always 1 → states 0,1,2,4; `reg_we` = `reg_dst` = 1 in WB; `retire_count` = 1 after 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEM → 7 cycles total; `mem_to_reg` = 1 and `reg_we` = 1 in WB; `alu_op` = 000, `ext_op` = 1.
- beq then bne → `nPC_sel` 10 then 11, each with a single `pc_we` pulse in EXEC; 3 cycles each.
- j → `pc_we` = 1 and `j_sel` = 1 in DECODE; back in FETCH on the next cycle.
- opcode 0x3F, or R-type funct 0x00 → HALT, `fault` = 1; stays halted for 20 cycles; `rst` clears to FETCH with `fault` = 0.
- `MAX_WAIT` = 3, `mem_ready` held 0 in FETCH → HALT after 3 wait cycles. Repeat with `mem_ready` = 1 on the 3rd cycle → DECODE, no fault.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the MiniSys CPU.
//
// Sequences instruction fetch, register read, ALU, data memory and write-back
// over 2-5 cycles per instruction. Memory accesses (instruction fetch, lw, sw)
// wait on a shared mem_ready handshake. If an access times out, or DECODE sees
// an unsupported instruction, the core halts with a sticky fault that only rst
// clears.
//
// Parameters:
//   MAX_WAIT      wait cycles allowed for mem_ready before a timeout (1-255)
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   opcode/funct  instruction[31:26] / instruction[5:0] from the IR
//   mem_ready     memory access completes this cycle
//   ir_we         latch the fetched word into the IR
//   pc_we         fetch unit updates the PC (one pulse per retired instruction)
//   nPC_sel       next-PC select: 00 = +4, 10 = beq, 11 = bne
//   j_sel         jump target select
//   mem_re/mem_we memory read (fetch or lw) / memory write (sw)
//   reg_we        register file write
//   reg_dst       write register: 1 = rd, 0 = rt
//   mem_to_reg    write-back source: 1 = memory, 0 = ALU
//   alu_src       ALU B source: 1 = immediate, 0 = rt
//   ext_op        immediate extension: 1 = sign, 0 = zero
//   alu_op        000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 LUI
//   state         current FSM state (debug)
//   fault         sticky halt flag
//   retire_count  count of retired instructions (wraps)
module multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  nPC_sel,
  output logic        j_sel,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluLui = 3'b101;

  localparam logic [1:0] NpcSeq = 2'b00;
  localparam logic [1:0] NpcBeq = 2'b10;
  localparam logic [1:0] NpcBne = 2'b11;

  // Value of wait_cnt during the last permitted wait cycle.
  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] retire_count_q, retire_count_d;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic       is_rtype, is_j, is_beq, is_bne, is_addiu, is_ori, is_lui, is_lw, is_sw;
  logic       funct_valid;
  logic [2:0] funct_alu_op;
  logic       op_valid;

  assign is_rtype = (opcode == OpRtype);
  assign is_j     = (opcode == OpJ);
  assign is_beq   = (opcode == OpBeq);
  assign is_bne   = (opcode == OpBne);
  assign is_addiu = (opcode == OpAddiu);
  assign is_ori   = (opcode == OpOri);
  assign is_lui   = (opcode == OpLui);
  assign is_lw    = (opcode == OpLw);
  assign is_sw    = (opcode == OpSw);

  always_comb begin
    funct_valid  = 1'b1;
    funct_alu_op = AluAdd;
    case (funct)
      6'h21:   funct_alu_op = AluAdd;
      6'h23:   funct_alu_op = AluSub;
      6'h24:   funct_alu_op = AluAnd;
      6'h25:   funct_alu_op = AluOr;
      6'h2A:   funct_alu_op = AluSlt;
      default: funct_valid  = 1'b0;
    endcase
  end

  // j is handled separately in DECODE and is not part of this set.
  assign op_valid = (is_rtype && funct_valid) || is_ori || is_addiu || is_lui ||
                    is_lw || is_sw || is_beq || is_bne;

  // ALU controls for the current instruction; only driven out in EXEC/MEM/WB.
  logic       ins_alu_src;
  logic       ins_ext_op;
  logic [2:0] ins_alu_op;

  always_comb begin
    ins_alu_src = 1'b0;
    ins_ext_op  = 1'b0;
    ins_alu_op  = AluAdd;
    if (is_rtype) begin
      ins_alu_op = funct_alu_op;
    end else if (is_ori) begin
      ins_alu_src = 1'b1;
      ins_alu_op  = AluOr;
    end else if (is_addiu || is_lw || is_sw) begin
      ins_alu_src = 1'b1;
      ins_ext_op  = 1'b1;
      ins_alu_op  = AluAdd;
    end else if (is_lui) begin
      ins_alu_src = 1'b1;
      ins_alu_op  = AluLui;
    end else if (is_beq || is_bne) begin
      ins_alu_op = AluSub;
    end
  end

  // mem_ready low on the last permitted wait cycle; mem_ready in that same
  // cycle wins, so the timeout is qualified with !mem_ready.
  logic mem_timeout;
  assign mem_timeout = !mem_ready && (wait_cnt_q == WaitLast);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StFetch;
      wait_cnt_q     <= 8'd0;
      fault_q        <= 1'b0;
      retire_count_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      fault_q        <= fault_d;
      retire_count_q <= retire_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (mem_timeout) begin
          state_d = StHalt;
        end
      end
      StDecode: begin
        if (is_j) begin
          state_d = StFetch;
        end else if (op_valid) begin
          state_d = StExec;
        end else begin
          state_d = StHalt;
        end
      end
      StExec: begin
        if (is_beq || is_bne) begin
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) begin
          state_d = is_lw ? StWb : StFetch;
        end else if (mem_timeout) begin
          state_d = StHalt;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // Counters and the sticky fault flag.
  always_comb begin
    fault_d = fault_q;
    if (state_d == StHalt) begin
      fault_d = 1'b1;
    end

    wait_cnt_d = 8'd0;
    if ((state_d == state_q) && !mem_ready &&
        ((state_q == StFetch) || (state_q == StMem))) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    retire_count_d = retire_count_q;
    if (pc_we) begin
      retire_count_d = retire_count_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    nPC_sel    = NpcSeq;
    j_sel      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = AluAdd;
    unique case (state_q)
      StFetch: begin
        mem_re = 1'b1;
        ir_we  = mem_ready;
      end
      StDecode: begin
        if (is_j) begin
          pc_we = 1'b1;
          j_sel = 1'b1;
        end
      end
      StExec: begin
        alu_src = ins_alu_src;
        ext_op  = ins_ext_op;
        alu_op  = ins_alu_op;
        if (is_beq) begin
          pc_we   = 1'b1;
          nPC_sel = NpcBeq;
        end else if (is_bne) begin
          pc_we   = 1'b1;
          nPC_sel = NpcBne;
        end
      end
      StMem: begin
        alu_src = ins_alu_src;
        ext_op  = ins_ext_op;
        alu_op  = ins_alu_op;
        mem_re  = is_lw;
        mem_we  = is_sw;
        // sw retires here; lw still has write-back ahead.
        if (is_sw && mem_ready) begin
          pc_we = 1'b1;
        end
      end
      StWb: begin
        alu_src    = ins_alu_src;
        ext_op     = ins_ext_op;
        alu_op     = ins_alu_op;
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = is_lw;
      end
      default: ;
    endcase
  end

  assign state        = state_q;
  assign fault        = fault_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: cycle-by-cycle vector table for the normal
// instruction mix, plus hand-written sequences for halts, timeouts and resets.
module tb_multicycle_ctrl;

  localparam int unsigned MaxWait = 3;

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StExec   = 3'd2;
  localparam logic [2:0] StMem    = 3'd3;
  localparam logic [2:0] StWb     = 3'd4;
  localparam logic [2:0] StHalt   = 3'd5;

  localparam logic [5:0] OpR = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
  localparam logic [5:0] OpAddiu = 6'h09, OpOri = 6'h0D, OpLui = 6'h0F;
  localparam logic [5:0] OpLw = 6'h23, OpSw = 6'h2B;
  localparam logic [14:0] Nil = 15'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        mem_ready = 1'b0;
  logic        ir_we, pc_we, j_sel, mem_re, mem_we, reg_we, reg_dst, mem_to_reg;
  logic        alu_src, ext_op, fault;
  logic [1:0]  nPC_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .nPC_sel(nPC_sel), .j_sel(j_sel),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op),
    .state(state), .fault(fault), .retire_count(retire_count)
  );

  // {ir_we, pc_we, nPC_sel, j_sel, mem_re, mem_we, reg_we, reg_dst, mem_to_reg,
  //  alu_src, ext_op, alu_op}
  logic [14:0] ctl_obs;
  assign ctl_obs = {ir_we, pc_we, nPC_sel, j_sel, mem_re, mem_we, reg_we, reg_dst,
                    mem_to_reg, alu_src, ext_op, alu_op};

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [2:0]  st;
    logic [14:0] ctl;
    logic        flt;
    logic [31:0] rc;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rc = 32'd0;

  function automatic logic [14:0] mk(input logic ir, input logic pc, input logic [1:0] npc,
                                     input logic j, input logic re, input logic we,
                                     input logic rwe, input logic rdst, input logic m2r,
                                     input logic asrc, input logic ext,
                                     input logic [2:0] aop);
    return {ir, pc, npc, j, re, we, rwe, rdst, m2r, asrc, ext, aop};
  endfunction

  function automatic logic [14:0] fetch(input logic r);
    return mk(r, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endfunction

  function automatic logic [14:0] ex(input logic asrc, input logic ext, input logic [2:0] aop);
    return mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, asrc, ext, aop);
  endfunction

  function automatic logic [14:0] wbk(input logic rdst, input logic m2r, input logic asrc,
                                      input logic ext, input logic [2:0] aop);
    return mk(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, rdst, m2r, asrc, ext, aop);
  endfunction

  function automatic logic [14:0] br(input logic [1:0] npc);
    return mk(1'b0, 1'b1, npc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
  endfunction

  function automatic logic [14:0] jmp();
    return mk(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
  endfunction

  function automatic logic [14:0] memc(input logic re, input logic we, input logic pc);
    return mk(1'b0, pc, 2'b00, 1'b0, re, we, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then check mid-low-phase.
  task automatic apply(input vec_t v);
    @(negedge clk);
    opcode    = v.op;
    funct     = v.fn;
    mem_ready = v.rdy;
    #1;
    chk($sformatf("%s.state", v.name), 64'(state), 64'(v.st));
    chk($sformatf("%s.ctl", v.name), 64'(ctl_obs), 64'(v.ctl));
    chk($sformatf("%s.fault_rc", v.name), {31'd0, fault, retire_count}, {31'd0, v.flt, v.rc});
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input logic [2:0] st, input logic [14:0] ctl,
                     input logic flt);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.ctl = ctl;
    v.flt = flt; v.rc = model_rc;
    vecs.push_back(v);
    if (ctl[13]) model_rc = model_rc + 32'd1;
  endtask

  task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [2:0] st, input logic [14:0] ctl,
                      input logic flt);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.ctl = ctl;
    v.flt = flt; v.rc = model_rc;
    apply(v);
    if (ctl[13]) model_rc = model_rc + 32'd1;
  endtask

  // HALT must ignore every input and hold all strobes low.
  task automatic hold_halt(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      step(nm, 6'(i * 7), 6'(i * 5), i[0], StHalt, Nil, 1'b1);
    end
  endtask

  // Asynchronous reset mid-cycle; effect is checked before the next clock edge.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk($sformatf("%s.rst_state", nm), 64'(state), 64'(StFetch));
    chk($sformatf("%s.rst_ctl", nm), 64'(ctl_obs), 64'(fetch(1'b0)));
    chk($sformatf("%s.rst_fault_rc", nm), {31'd0, fault, retire_count}, 64'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_rc = 32'd0;
  endtask

  logic [5:0] r_fn  [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
  logic [2:0] r_aop [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
  string      r_nm  [5] = '{"addu", "subu", "and", "or", "slt"};
  logic [5:0] i_op  [3] = '{OpOri, OpAddiu, OpLui};
  logic       i_ext [3] = '{1'b0, 1'b1, 1'b0};
  logic [2:0] i_aop [3] = '{3'b011, 3'b000, 3'b101};
  string      i_nm  [3] = '{"ori", "addiu", "lui"};

  initial begin
    // ---- vector table: straight-line program, no reset in between ----
    for (int k = 0; k < 5; k++) begin
      add(r_nm[k], OpR, r_fn[k], 1'b1, StFetch,  fetch(1'b1), 1'b0);
      add(r_nm[k], OpR, r_fn[k], 1'b1, StDecode, Nil, 1'b0);
      add(r_nm[k], OpR, r_fn[k], 1'b0, StExec,   ex(1'b0, 1'b0, r_aop[k]), 1'b0);
      add(r_nm[k], OpR, r_fn[k], 1'b1, StWb,     wbk(1'b1, 1'b0, 1'b0, 1'b0, r_aop[k]), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      add(i_nm[k], i_op[k], 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
      add(i_nm[k], i_op[k], 6'h00, 1'b0, StDecode, Nil, 1'b0);
      add(i_nm[k], i_op[k], 6'h00, 1'b0, StExec,   ex(1'b1, i_ext[k], i_aop[k]), 1'b0);
      add(i_nm[k], i_op[k], 6'h00, 1'b0, StWb,
          wbk(1'b0, 1'b0, 1'b1, i_ext[k], i_aop[k]), 1'b0);
    end
    // lw: two fetch waits then ready on the last permitted cycle, two MEM waits
    add("lw", OpLw, 6'h00, 1'b0, StFetch,  fetch(1'b0), 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StFetch,  fetch(1'b0), 1'b0);
    add("lw", OpLw, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StExec,   ex(1'b1, 1'b1, 3'b000), 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StMem,    memc(1'b1, 1'b0, 1'b0), 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StMem,    memc(1'b1, 1'b0, 1'b0), 1'b0);
    add("lw", OpLw, 6'h00, 1'b1, StMem,    memc(1'b1, 1'b0, 1'b0), 1'b0);
    add("lw", OpLw, 6'h00, 1'b0, StWb,     wbk(1'b0, 1'b1, 1'b1, 1'b1, 3'b000), 1'b0);
    // sw with one MEM wait
    add("sw", OpSw, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    add("sw", OpSw, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    add("sw", OpSw, 6'h00, 1'b1, StExec,   ex(1'b1, 1'b1, 3'b000), 1'b0);
    add("sw", OpSw, 6'h00, 1'b0, StMem,    memc(1'b0, 1'b1, 1'b0), 1'b0);
    add("sw", OpSw, 6'h00, 1'b1, StMem,    memc(1'b0, 1'b1, 1'b1), 1'b0);
    // beq / bne / j
    add("beq", OpBeq, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    add("beq", OpBeq, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    add("beq", OpBeq, 6'h00, 1'b0, StExec,   br(2'b10), 1'b0);
    add("bne", OpBne, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    add("bne", OpBne, 6'h00, 1'b1, StDecode, Nil, 1'b0);
    add("bne", OpBne, 6'h00, 1'b1, StExec,   br(2'b11), 1'b0);
    add("j",   OpJ,   6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    add("j",   OpJ,   6'h00, 1'b0, StDecode, jmp(), 1'b0);
    add("j_back", OpJ, 6'h00, 1'b0, StFetch, fetch(1'b0), 1'b0);

    // ---- reset state ----
    #1 rst = 1'b1;
    #1;
    chk("reset.state", 64'(state), 64'(StFetch));
    chk("reset.ctl_rdy0", 64'(ctl_obs), 64'(fetch(1'b0)));
    chk("reset.fault_rc", {31'd0, fault, retire_count}, 64'd0);
    mem_ready = 1'b1;
    #1;
    chk("reset.ctl_rdy1", 64'(ctl_obs), 64'(fetch(1'b1)));
    @(posedge clk);
    #1;
    chk("reset.held", 64'(state), 64'(StFetch));
    rst       = 1'b0;
    mem_ready = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // ---- unknown opcode halts, stays halted, reset recovers ----
    step("bad_op", 6'h3F, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("bad_op", 6'h3F, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    hold_halt("bad_op_halt", 20);
    do_reset("bad_op");

    // ---- R-type with unsupported funct ----
    step("bad_fn", OpR, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("bad_fn", OpR, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    hold_halt("bad_fn_halt", 3);
    do_reset("bad_fn");

    // ---- fetch timeout after MaxWait wait cycles ----
    for (int i = 0; i < 3; i++) step("fetch_to", OpR, 6'h21, 1'b0, StFetch, fetch(1'b0), 1'b0);
    hold_halt("fetch_to_halt", 2);
    do_reset("fetch_to");

    // ---- MEM timeout on sw ----
    step("mem_to", OpSw, 6'h00, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("mem_to", OpSw, 6'h00, 1'b0, StDecode, Nil, 1'b0);
    step("mem_to", OpSw, 6'h00, 1'b0, StExec,   ex(1'b1, 1'b1, 3'b000), 1'b0);
    for (int i = 0; i < 3; i++) step("mem_to", OpSw, 6'h00, 1'b0, StMem, memc(1'b0, 1'b1, 1'b0), 1'b0);
    hold_halt("mem_to_halt", 2);
    do_reset("mem_to");

    // ---- reset mid-instruction aborts it ----
    step("pre", OpR, 6'h21, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("pre", OpR, 6'h21, 1'b0, StDecode, Nil, 1'b0);
    step("pre", OpR, 6'h21, 1'b0, StExec,   ex(1'b0, 1'b0, 3'b000), 1'b0);
    step("pre", OpR, 6'h21, 1'b0, StWb,     wbk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000), 1'b0);
    step("abort", OpR, 6'h25, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("abort", OpR, 6'h25, 1'b0, StDecode, Nil, 1'b0);
    do_reset("abort");
    step("post", OpR, 6'h25, 1'b1, StFetch,  fetch(1'b1), 1'b0);
    step("post", OpR, 6'h25, 1'b0, StDecode, Nil, 1'b0);
    step("post", OpR, 6'h25, 1'b0, StExec,   ex(1'b0, 1'b0, 3'b011), 1'b0);
    step("post", OpR, 6'h25, 1'b0, StWb,     wbk(1'b1, 1'b0, 1'b0, 1'b0, 3'b011), 1'b0);
    step("post", OpR, 6'h25, 1'b0, StFetch,  fetch(1'b0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
